ghost_mode_ctrl: RTL and testbench

GHOST_MODE_CTRL -- requirements
Module: ghost_mode_ctrl

---
 rtl/ghost_mode_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ghost_mode_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_mode_ctrl.sv
// ghost_mode_ctrl: ghost behaviour sequencer (IDLE / SCATTER / CHASE / FRIGHT).
// A frame tick derived from frame_clk drives the scatter/chase schedule, the
// frightened countdown and the staggered ghost-house releases.
// Optional feature macro: GHOST_FRIGHT_FLASH_EN builds the flashing-blue
// indicator for the last FLASH_TICKS of frightened mode. When the macro is
// undefined, fright_flash is tied low and no comparator is built.
module ghost_mode_ctrl #(
    parameter int SCATTER_TICKS = 420,
    parameter int CHASE_TICKS   = 1200,
    parameter int FRIGHT_TICKS  = 360,
    parameter int FLASH_TICKS   = 120,
    parameter int RELEASE_TICKS = 240
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       game_start,
    input  logic       power_pellet,
    input  logic       lifeDown,
    output logic [1:0] mode,
    output logic [2:0] phase,
    output logic       reverse,
    output logic       fright_flash,
    output logic [3:0] ghost_release
);

    // State encoding equals the mode output encoding
    localparam logic [1:0] ST_SCATTER = 2'b00;
    localparam logic [1:0] ST_CHASE   = 2'b01;
    localparam logic [1:0] ST_FRIGHT  = 2'b10;
    localparam logic [1:0] ST_IDLE    = 2'b11;

    localparam logic [10:0] CNT_MAX     = 11'h7FF;
    localparam logic [10:0] SCATTER_LIM = 11'(SCATTER_TICKS);
    localparam logic [10:0] CHASE_LIM   = 11'(CHASE_TICKS);
    localparam logic [10:0] FRIGHT_LIM  = 11'(FRIGHT_TICKS);
    localparam logic [10:0] RELEASE_LIM = 11'(RELEASE_TICKS);

    // All tick counts must fit the 11-bit saturating counters
    if (SCATTER_TICKS < 1 || SCATTER_TICKS > 2047 || CHASE_TICKS < 1 || CHASE_TICKS > 2047 ||
        FRIGHT_TICKS < 1 || FRIGHT_TICKS > 2047 || RELEASE_TICKS < 1 || RELEASE_TICKS > 2047 ||
        FLASH_TICKS < 0 || FLASH_TICKS > FRIGHT_TICKS) begin : g_bad_params
        $error("ghost_mode_ctrl: tick parameter out of range");
    end

    logic        frame_sync1_reg, frame_sync2_reg, frame_edge_reg, tick_reg;
    logic [1:0]  state_reg, state_next;
    logic [2:0]  phase_reg, phase_next;
    logic [10:0] phase_timer_reg, phase_timer_next;
    logic [10:0] fright_timer_reg, fright_timer_next;
    logic [10:0] release_cnt_reg, release_cnt_next;
    logic [3:0]  release_reg, release_next;
    logic        reverse_reg, reverse_next;

    logic        tick_ok;
    logic [10:0] phase_limit, phase_timer_inc, release_cnt_inc;
    logic [3:0]  lower_set, release_grant;

    // Synchronize frame_clk and register a single-cycle tick on its rising edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_sync1_reg <= 1'b0;
            frame_sync2_reg <= 1'b0;
            frame_edge_reg  <= 1'b0;
            tick_reg        <= 1'b0;
        end else begin
            frame_sync1_reg <= frame_clk;
            frame_sync2_reg <= frame_sync1_reg;
            frame_edge_reg  <= frame_sync2_reg;
            tick_reg        <= frame_sync2_reg & ~frame_edge_reg;
        end
    end

    // Lowest ghost still in the house: one-hot grant over the clear bits
    assign lower_set[0] = 1'b1;
    for (genvar gi = 1; gi < 4; gi++) begin : g_lower
        assign lower_set[gi] = lower_set[gi-1] & release_reg[gi-1];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_grant
        assign release_grant[gi] = lower_set[gi] & ~release_reg[gi];
    end

    // Next-state logic: lifeDown beats power_pellet beats tick-driven expiry
    always_comb begin
        state_next        = state_reg;
        phase_next        = phase_reg;
        phase_timer_next  = phase_timer_reg;
        fright_timer_next = fright_timer_reg;
        release_cnt_next  = release_cnt_reg;
        release_next      = release_reg;
        reverse_next      = 1'b0;

        // A tick landing together with game_start or lifeDown is dropped
        tick_ok         = tick_reg & ~game_start & ~lifeDown;
        phase_limit     = phase_reg[0] ? CHASE_LIM : SCATTER_LIM;
        phase_timer_inc = (phase_timer_reg == CNT_MAX) ? CNT_MAX : phase_timer_reg + 11'd1;
        release_cnt_inc = (release_cnt_reg == CNT_MAX) ? CNT_MAX : release_cnt_reg + 11'd1;

        if (state_reg == ST_IDLE) begin
            if (game_start) begin
                state_next        = ST_SCATTER;
                phase_next        = 3'd0;
                phase_timer_next  = 11'd0;
                fright_timer_next = 11'd0;
                release_cnt_next  = 11'd0;
                release_next      = 4'b0001;
            end
        end else if (lifeDown) begin
            state_next        = ST_SCATTER;
            phase_next        = 3'd0;
            phase_timer_next  = 11'd0;
            fright_timer_next = 11'd0;
            release_cnt_next  = 11'd0;
            release_next      = 4'b0001;
        end else if (power_pellet) begin
            // Entering fright reverses the ghosts; a refresh while frightened does not
            reverse_next      = (state_reg != ST_FRIGHT);
            state_next        = ST_FRIGHT;
            fright_timer_next = FRIGHT_LIM;
        end else if (tick_ok) begin
            if (state_reg == ST_FRIGHT) begin
                if (fright_timer_reg <= 11'd1) begin
                    // Resume the schedule where it was frozen
                    fright_timer_next = 11'd0;
                    state_next        = phase_reg[0] ? ST_CHASE : ST_SCATTER;
                end else begin
                    fright_timer_next = fright_timer_reg - 11'd1;
                end
            end else begin
                if (release_reg != 4'b1111) begin
                    if (release_cnt_inc >= RELEASE_LIM) begin
                        release_next     = release_reg | release_grant;
                        release_cnt_next = 11'd0;
                    end else begin
                        release_cnt_next = release_cnt_inc;
                    end
                end
                // Phase 7 is the final, untimed chase
                if ((phase_reg != 3'd7) && (phase_timer_inc >= phase_limit)) begin
                    phase_next       = phase_reg + 3'd1;
                    phase_timer_next = 11'd0;
                    reverse_next     = 1'b1;
                    state_next       = phase_reg[0] ? ST_SCATTER : ST_CHASE;
                end else begin
                    phase_timer_next = phase_timer_inc;
                end
            end
        end
    end

    // State, timers and release mask registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg        <= ST_IDLE;
            phase_reg        <= 3'd0;
            phase_timer_reg  <= 11'd0;
            fright_timer_reg <= 11'd0;
            release_cnt_reg  <= 11'd0;
            release_reg      <= 4'b0000;
            reverse_reg      <= 1'b0;
        end else begin
            state_reg        <= state_next;
            phase_reg        <= phase_next;
            phase_timer_reg  <= phase_timer_next;
            fright_timer_reg <= fright_timer_next;
            release_cnt_reg  <= release_cnt_next;
            release_reg      <= release_next;
            reverse_reg      <= reverse_next;
        end
    end

    assign mode          = state_reg;
    assign phase         = phase_reg;
    assign reverse       = reverse_reg;
    assign ghost_release = release_reg;

`ifdef GHOST_FRIGHT_FLASH_EN
    localparam logic [10:0] FLASH_LIM = 11'(FLASH_TICKS);
    assign fright_flash = (state_reg == ST_FRIGHT) && (fright_timer_reg <= FLASH_LIM);
`else
    assign fright_flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Self-checking bench for ghost_mode_ctrl with small tick parameters.
module tb_ghost_mode_ctrl;
    localparam int SC = 4;
    localparam int CH = 6;
    localparam int FR = 5;
    localparam int FL = 2;
    localparam int RL = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic       game_start = 1'b0;
    logic       power_pellet = 1'b0;
    logic       lifeDown = 1'b0;
    logic [1:0] mode;
    logic [2:0] phase;
    logic       reverse;
    logic       fright_flash;
    logic [3:0] ghost_release;

    always #5 Clk = ~Clk;

    ghost_mode_ctrl #(
        .SCATTER_TICKS(SC), .CHASE_TICKS(CH), .FRIGHT_TICKS(FR),
        .FLASH_TICKS(FL), .RELEASE_TICKS(RL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_start(game_start),
        .power_pellet(power_pellet), .lifeDown(lifeDown), .mode(mode), .phase(phase),
        .reverse(reverse), .fright_flash(fright_flash), .ghost_release(ghost_release)
    );

    int checks = 0;
    int failures = 0;
    int rev_count = 0;
    int rev_start = 0;

    // Behavioural model: game-level quantities, not register images
    bit m_active = 0;
    bit m_fright = 0;
    int m_phase = 0;
    int m_elapsed = 0;
    int m_fright_left = 0;
    int m_released = 0;
    int m_rel_ticks = 0;
    int m_rev = 0;

    // Count reverse cycles shortly after each clock edge
    always @(posedge Clk) begin
        #1;
        if (reverse === 1'b1) rev_count++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_mode();
        if (!m_active) return 3;
        if (m_fright) return 2;
        return m_phase % 2;
    endfunction

    function automatic int exp_flash();
`ifdef GHOST_FRIGHT_FLASH_EN
        return (m_active && m_fright && m_fright_left <= FL) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".mode"}, 32'(mode), exp_mode());
        check({tag, ".phase"}, 32'(phase), m_phase);
        check({tag, ".release"}, 32'(ghost_release), (1 << m_released) - 1);
        check({tag, ".flash"}, 32'(fright_flash), exp_flash());
        check({tag, ".reverse"}, rev_count - rev_start, m_rev);
        $display("[%0t] %s mode=%0d phase=%0d release=%b flash=%0b rev=%0d",
                 $time, tag, mode, phase, ghost_release, fright_flash, rev_count - rev_start);
    endtask

    task automatic model_restart();
        m_phase = 0; m_elapsed = 0; m_fright = 0; m_fright_left = 0;
        m_released = 1; m_rel_ticks = 0;
    endtask

    task automatic model_tick();
        m_rev = 0;
        if (!m_active) return;
        if (m_fright) begin
            m_fright_left--;
            if (m_fright_left == 0) m_fright = 0;
            return;
        end
        m_rel_ticks++;
        if (m_released < 4 && m_rel_ticks == RL) begin
            m_released++;
            m_rel_ticks = 0;
        end
        m_elapsed++;
        if (m_phase < 7 && m_elapsed == ((m_phase % 2) ? CH : SC)) begin
            m_phase++;
            m_elapsed = 0;
            m_rev = 1;
        end
    endtask

    task automatic model_events(input bit gs, input bit pp, input bit ld);
        m_rev = 0;
        if (!m_active) begin
            if (gs) begin
                m_active = 1;
                model_restart();
            end
        end else if (ld) begin
            model_restart();
        end else if (pp) begin
            if (!m_fright) m_rev = 1;
            m_fright = 1;
            m_fright_left = FR;
        end
    endtask

    // One-cycle control pulses applied together
    task automatic pulse(input bit gs, input bit pp, input bit ld, input string tag);
        rev_start = rev_count;
        @(negedge Clk);
        game_start = gs; power_pellet = pp; lifeDown = ld;
        @(negedge Clk);
        game_start = 0; power_pellet = 0; lifeDown = 0;
        model_events(gs, pp, ld);
        check_all(tag);
    endtask

    // One frame_clk period; optional pulses coincide with the internal tick
    task automatic do_tick(input bit gs, input bit ld, input string tag);
        rev_start = rev_count;
        @(negedge Clk);
        frame_clk = 1;
        repeat (3) @(negedge Clk);
        if (!gs && !ld) begin
            check({tag, ".latency_mode"}, 32'(mode), exp_mode());
            check({tag, ".latency_phase"}, 32'(phase), m_phase);
        end
        game_start = gs; lifeDown = ld;
        @(negedge Clk);
        game_start = 0; lifeDown = 0;
        frame_clk = 0;
        if (gs || ld) model_events(gs, 0, ld);
        else model_tick();
        check_all(tag);
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        m_rev = 0;
        rev_start = rev_count;
        check_all("reset");
        @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        check_all("idle_before_start");
        do_tick(0, 0, "idle_tick");
        pulse(0, 1, 0, "idle_pellet");
        pulse(1, 0, 0, "game_start");

        // First scatter: releases and the first phase change
        for (int i = 0; i < 4; i++) do_tick(0, 0, "scatter0");
        for (int i = 0; i < CH; i++) do_tick(0, 0, "chase1");
        // Phase 2, pellet at phase-timer 2
        for (int i = 0; i < 2; i++) do_tick(0, 0, "scatter2");
        pulse(0, 1, 0, "pellet_enter");
        for (int i = 0; i < 3; i++) do_tick(0, 0, "fright");
        pulse(0, 1, 0, "pellet_refresh");
        for (int i = 0; i < FR; i++) do_tick(0, 0, "fright_refreshed");
        for (int i = 0; i < 2; i++) do_tick(0, 0, "scatter2_resume");
        for (int i = 0; i < 3; i++) do_tick(0, 0, "chase3");
        pulse(0, 1, 1, "life_and_pellet");

        // Ticks coinciding with lifeDown / game_start are dropped
        for (int i = 0; i < 2; i++) do_tick(0, 0, "pre_discard");
        do_tick(0, 1, "tick_with_lifedown");
        do_tick(1, 0, "tick_with_start");
        pulse(1, 0, 0, "start_while_active");

        // Run the whole schedule into the untimed final chase
        pulse(0, 0, 1, "life_restart");
        for (int i = 0; i < 45; i++) do_tick(0, 0, "long_run");

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 72)      do_tick(0, 0, "rnd_tick");
            else if (r < 82) pulse(0, 1, 0, "rnd_pellet");
            else if (r < 85) pulse(0, 0, 1, "rnd_life");
            else if (r < 88) pulse(0, 1, 1, "rnd_life_pellet");
            else if (r < 92) do_tick(0, 1, "rnd_tick_life");
            else if (r < 96) do_tick(1, 0, "rnd_tick_start");
            else             pulse(1, 0, 0, "rnd_start");
        end

        // Asynchronous reset in the middle of frightened mode
        pulse(0, 0, 1, "pre_reset_life");
        pulse(0, 1, 0, "pre_reset_pellet");
        do_tick(0, 0, "pre_reset_fright");
        do_tick(0, 0, "pre_reset_fright");
        @(negedge Clk);
        #2;
        rev_start = rev_count;
        Reset = 0;
        #1;
        m_active = 0;
        model_restart();
        m_released = 0;
        m_rev = 0;
        check_all("async_reset");
        @(negedge Clk);
        Reset = 1;
        @(negedge Clk);
        rev_start = rev_count;
        check_all("after_reset");
        do_tick(0, 0, "idle_tick2");
        pulse(1, 0, 0, "restart");
        for (int i = 0; i < 5; i++) do_tick(0, 0, "post_restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
